md_unit_param: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Successor to the fixed 32-bit, fixed-latency MD unit.
- Operand width and mult/div latencies are configurable, and the unit supports exception-request squashing.
- The hazard controller reads `busy` (and `start`) to stall MD-dependent instructions in D.

---
 rtl/md_unit_param_if.sv | 24 ++
 rtl/md_unit_param.sv | 184 ++++++++++++++++++
 tb/tb_md_unit_param.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_param_if.sv
// Handshake/bus bundle for md_unit_param: operation request from the E stage
// and the busy/HI/LO view returned to the pipeline and hazard controller.
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       md_op;
    logic             start;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             req;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output md_op, start, rs_data, rt_data, req,
        input  busy, hi, lo
    );

    modport slave (
        input  md_op, start, rs_data, rt_data, req,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO registers (MIPS E stage).
// The full result is computed at launch into a shadow register; HI/LO are
// only written when the configured latency has elapsed.
// Optional feature macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (codes 7-10),
// which accumulate into {hi,lo} as it stands at completion time.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    md_unit_param_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // How the shadow result is folded into {hi,lo} at completion
    localparam logic [1:0] MODE_SET  = 2'd0;
    localparam logic [1:0] MODE_KEEP = 2'd1;
    localparam logic [1:0] MODE_ADD  = 2'd2;
    localparam logic [1:0] MODE_SUB  = 2'd3;

    // Full-width product; signed operands are sign-extended before multiplying
    function automatic logic [2*WIDTH-1:0] mul_result(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic           sgn);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    // {remainder, quotient}; signed case divides magnitudes then restores signs,
    // which yields most-negative/-1 = most-negative remainder 0 naturally
    function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] n,
                                                      input logic [WIDTH-1:0] d,
                                                      input logic           sgn);
        logic             n_neg;
        logic             d_neg;
        logic [WIDTH-1:0] an;
        logic [WIDTH-1:0] ad;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        n_neg = sgn & n[WIDTH-1];
        d_neg = sgn & d[WIDTH-1];
        an    = n_neg ? -n : n;
        ad    = d_neg ? -d : d;
        q     = an / ad;
        r     = an % ad;
        if (n_neg ^ d_neg) q = -q;
        else               q = q;
        if (n_neg) r = -r;
        else       r = r;
        return {r, q};
    endfunction

    logic [0:0]         state_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] shadow_r;
    logic [1:0]         mode_r;

    logic               is_mul_s;
    logic               is_div_s;
    logic               sgn_s;
    logic [1:0]         acc_mode_s;
    logic               launch_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic [WIDTH-1:0]   divisor_s;
    logic [2*WIDTH-1:0] result_s;
    logic [1:0]         mode_s;
    logic [2*WIDTH-1:0] acc_s;
    logic [2*WIDTH-1:0] final_s;

    // Decode the operation code into class, signedness and accumulate mode
    always_comb begin
        is_mul_s   = 1'b0;
        is_div_s   = 1'b0;
        sgn_s      = 1'b0;
        acc_mode_s = MODE_SET;
        case (bus.md_op)
            4'd1:    begin is_mul_s = 1'b1; sgn_s = 1'b1; end
            4'd2:    begin is_mul_s = 1'b1; end
            4'd3:    begin is_div_s = 1'b1; sgn_s = 1'b1; end
            4'd4:    begin is_div_s = 1'b1; end
`ifdef MD_MADD_EN
            4'd7:    begin is_mul_s = 1'b1; sgn_s = 1'b1; acc_mode_s = MODE_ADD; end
            4'd8:    begin is_mul_s = 1'b1; acc_mode_s = MODE_ADD; end
            4'd9:    begin is_mul_s = 1'b1; sgn_s = 1'b1; acc_mode_s = MODE_SUB; end
            4'd10:   begin is_mul_s = 1'b1; acc_mode_s = MODE_SUB; end
`endif
            default: begin is_mul_s = 1'b0; is_div_s = 1'b0; end
        endcase
    end

    // Launch and move qualification: only from IDLE and never in a squashed cycle
    always_comb begin
        launch_s = (state_r == IDLE) & bus.start & ~bus.req & (is_mul_s | is_div_s);
        mthi_s   = (state_r == IDLE) & ~bus.req & (bus.md_op == 4'd5);
        mtlo_s   = (state_r == IDLE) & ~bus.req & (bus.md_op == 4'd6);
    end

    // Compute the shadow result; divide by zero keeps HI/LO at completion
    always_comb begin
        result_s = '0;
        mode_s   = MODE_SET;
        if (bus.rt_data == '0) divisor_s = {{(WIDTH-1){1'b0}}, 1'b1};
        else                   divisor_s = bus.rt_data;
        if (is_div_s) begin
            result_s = div_result(bus.rs_data, divisor_s, sgn_s);
            if (bus.rt_data == '0) mode_s = MODE_KEEP;
            else                   mode_s = MODE_SET;
        end else begin
            result_s = mul_result(bus.rs_data, bus.rt_data, sgn_s);
            mode_s   = acc_mode_s;
        end
    end

    // Fold the shadow result into the current {hi,lo} at completion
    always_comb begin
        acc_s = {hi_r, lo_r};
        case (mode_r)
            MODE_SET:  final_s = shadow_r;
            MODE_KEEP: final_s = acc_s;
            MODE_ADD:  final_s = acc_s + shadow_r;
            MODE_SUB:  final_s = acc_s - shadow_r;
            default:   final_s = acc_s;
        endcase
    end

    // FSM, countdown, shadow capture and HI/LO register updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            shadow_r <= '0;
            mode_r   <= MODE_SET;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        shadow_r <= result_s;
                        mode_r   <= mode_s;
                        cnt_r    <= is_div_s ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else if (mthi_s) begin
                        hi_r <= bus.rs_data;
                    end else if (mtlo_s) begin
                        lo_r <= bus.rs_data;
                    end
                end
                RUN: begin
                    if (cnt_r == '0) begin
                        {hi_r, lo_r} <= final_s;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// A cycle-level behavioural model predicts busy/hi/lo; outputs are compared on
// every falling edge, with literal expectations for the directed scenarios.
module tb_md_unit_param;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

`ifdef MD_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   cmp_en;

    md_unit_param_if #(.WIDTH(W)) bus_if ();

    md_unit_param #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int          m_left;
    logic [3:0]  p_op;
    logic [31:0] p_a, p_b;
    logic [31:0] m_hi, m_lo;

    function automatic bit is_launch(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_EN && op >= 4'd7 && op <= 4'd10);
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] h,
                                                 input logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, acc, uq, ur;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {h, l};
        case (op)
            4'd1:  return sa * sb;
            4'd2:  return ua * ub;
            4'd3: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            4'd7:  return acc + sa * sb;
            4'd8:  return acc + ua * ub;
            4'd9:  return acc - sa * sb;
            4'd10: return acc - ua * ub;
            default: return acc;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy       <= 1'b0;
                {m_hi, m_lo} <= model_result(p_op, p_a, p_b, m_hi, m_lo);
            end
        end else if (!bus_if.req) begin
            if (bus_if.start && is_launch(bus_if.md_op)) begin
                p_op   <= bus_if.md_op;
                p_a    <= bus_if.rs_data;
                p_b    <= bus_if.rt_data;
                m_left <= (bus_if.md_op == 4'd3 || bus_if.md_op == 4'd4) ? DC : MC;
                m_busy <= 1'b1;
            end else if (bus_if.md_op == 4'd5) begin
                m_hi <= bus_if.rs_data;
            end else if (bus_if.md_op == 4'd6) begin
                m_lo <= bus_if.rs_data;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {63'd0, bus_if.busy}, {63'd0, m_busy});
            chk("hi", {32'd0, bus_if.hi}, {32'd0, m_hi});
            chk("lo", {32'd0, bus_if.lo}, {32'd0, m_lo});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus_if.md_op   = 4'd0;
        bus_if.start   = 1'b0;
        bus_if.req     = 1'b0;
        bus_if.rs_data = 32'd0;
        bus_if.rt_data = 32'd0;
    endtask

    // Present one operation for one rising edge, then return to idle inputs
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic st, input logic rq);
        bus_if.md_op   = op;
        bus_if.start   = st;
        bus_if.rs_data = rs;
        bus_if.rt_data = rt;
        bus_if.req     = rq;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Count falling edges with busy high until it drops (bounded)
    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_if.busy) return;
            cyc++;
        end
        chk("busy_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int cyc;

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        #1 rst_n = 1'b1;

        // 1. MULT / MULTU
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("mult_busy_cycles", 64'(cyc), 64'd5);
        chk("mult_hilo", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("multu_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0001_FFFF_FFFE);

        // 2. DIV / DIVU / overflow case
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("div_busy_cycles", 64'(cyc), 64'd10);
        chk("div_hilo", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4'd4, 32'd7, 32'd2, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("divu_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0001_0000_0003);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("div_ovf_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);

        // 3. squash
        issue(4'd1, 32'd3, 32'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("squash_mult_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("squash_mult_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);
        issue(4'd6, 32'h55, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("squash_mtlo", {32'd0, bus_if.lo}, 64'h8000_0000);
        issue(4'd6, 32'h55, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mtlo", {32'd0, bus_if.lo}, 64'h55);
        chk("mtlo_busy", {63'd0, bus_if.busy}, 64'd0);

        // 4. async reset mid-operation
        issue(4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
        issue(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("async_rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);

        // 5. divide by zero with an ignored start during busy
        issue(4'd5, 32'hAA, 32'd0, 1'b0, 1'b0);
        issue(4'd6, 32'hBB, 32'd0, 1'b0, 1'b0);
        issue(4'd3, 32'd9, 32'd0, 1'b1, 1'b0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_if.busy) break;
            cyc++;
            if (i == 3) begin
                bus_if.md_op = 4'd1; bus_if.start = 1'b1;
                bus_if.rs_data = 32'd3; bus_if.rt_data = 32'd4;
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
        chk("divz_busy_cycles", 64'(cyc), 64'd10);
        chk("divz_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_00AA_0000_00BB);

        // 6. MADDU / MSUB (or no-ops when the feature is absent)
        issue(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        issue(4'd8, 32'd1, 32'd1, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("maddu_busy_cycles", 64'(cyc), MADD_EN ? 64'd5 : 64'd0);
        chk("maddu_hilo", {bus_if.hi, bus_if.lo},
            MADD_EN ? 64'h0000_0001_0000_0000 : 64'h0000_0000_FFFF_FFFF);
        issue(4'd9, 32'd1, 32'd1, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("msub_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0000_FFFF_FFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus_if.md_op   = 4'($urandom_range(0, 15));
            bus_if.start   = ($urandom_range(0, 3) != 0);
            bus_if.req     = ($urandom_range(0, 9) == 0);
            bus_if.rs_data = pick();
            bus_if.rt_data = pick();
            @(negedge clk);
        end
        idle_inputs();
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
